// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port 32-bit word memory: round-robin grant,
// programmable access latency, alignment/range check and dump-strobe gating.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        m_enable,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        dump_req,
  output logic        m_createdump,
  output logic        busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            owner, owner_nxt;
  logic            last_owner, last_owner_nxt;
  logic            wr_q, wr_nxt;
  logic            err_q, err_nxt;
  logic            dump_pend, dump_pend_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [DW-1:0]   wdata_q, wdata_nxt;
  logic [DW-1:0]   i_rdata_nxt, d_rdata_nxt;
  logic            dump_c;
  logic            grant_d;
  logic            req_valid;
  logic [AW-1:0]   req_addr;

  // Word aligned and the whole word below the limit; sum kept at 33 bits so it cannot wrap.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && (({1'b0, a} + 33'd3) < {1'b0, ADDR_LIMIT});
  endfunction

  // Next-state, latch and read-data capture logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    wr_nxt         = wr_q;
    err_nxt        = err_q;
    dump_pend_nxt  = dump_pend;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    dump_c         = 1'b0;
    grant_d        = d_req && (!i_req || (last_owner == OWN_I));
    req_addr       = grant_d ? d_addr : i_addr;
    req_valid      = addr_ok(req_addr);

    case (state)
      IDLE: begin
        if (dump_req || dump_pend) begin
          dump_c        = 1'b1;
          dump_pend_nxt = 1'b0;
        end else if (i_req || d_req) begin
          owner_nxt = grant_d ? OWN_D : OWN_I;
          addr_nxt  = req_addr;
          wr_nxt    = grant_d && d_wr;
          wdata_nxt = grant_d ? d_wdata : '0;
          err_nxt   = !req_valid;
          if (req_valid) begin
            state_nxt = ACCESS;
            cnt_nxt   = CW'(LATENCY - 1);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      ACCESS: begin
        dump_pend_nxt = dump_pend || dump_req;
        if (cnt == '0) begin
          state_nxt = RESP;
          if (!wr_q) begin
            if (owner == OWN_D) d_rdata_nxt = m_rdata;
            else                i_rdata_nxt = m_rdata;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP: begin
        dump_pend_nxt  = dump_pend || dump_req;
        last_owner_nxt = owner;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latches and registered outputs; outputs are decoded from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      dump_pend  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_done     <= 1'b0;
      i_err      <= 1'b0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      m_enable   <= 1'b0;
      m_wr       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      wr_q       <= wr_nxt;
      err_q      <= err_nxt;
      dump_pend  <= dump_pend_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_done     <= (state_nxt == RESP) && (owner_nxt == OWN_I);
      i_err      <= (state_nxt == RESP) && (owner_nxt == OWN_I) && err_nxt;
      d_done     <= (state_nxt == RESP) && (owner_nxt == OWN_D);
      d_err      <= (state_nxt == RESP) && (owner_nxt == OWN_D) && err_nxt;
      m_enable   <= (state_nxt == ACCESS);
      // Write strobe only on the last enabled cycle so the memory sees exactly one write.
      m_wr       <= (state_nxt == ACCESS) && wr_nxt && (cnt_nxt == '0);
      m_addr     <= (state_nxt == ACCESS) ? addr_nxt : '0;
      m_wdata    <= (state_nxt == ACCESS) ? wdata_nxt : '0;
    end
  end

  assign m_createdump = dump_c && !rst;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural word memory, reference image of
// expected memory contents, and cycle arithmetic for grant order and latency.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done, i_err;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done, d_err;
  logic        m_enable, m_wr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        dump_req = 1'b0;
  logic        m_createdump, busy;

  mem_arbiter #(.LATENCY(LAT), .ADDR_LIMIT(32'h0001_0000)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_enable(m_enable), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .dump_req(dump_req), .m_createdump(m_createdump), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0, wr_cnt = 0, wr_cyc = -1, dump_cnt = 0, dump_cyc = -1;
  int i_done_cnt = 0, d_done_cnt = 0, bad_bus_cnt = 0;

  function automatic logic [31:0] init_word(input int idx);
    return 32'(idx) * 32'h9E37_79B9 ^ 32'h5A5A_1234;
  endfunction

  // Memory seen by the DUT.
  bit [31:0] mem    [16384];
  bit        mem_wr [16384];
  assign m_rdata = mem_wr[m_addr[15:2]] ? mem[m_addr[15:2]] : init_word(int'(m_addr[15:2]));

  always @(posedge clk) begin
    if (m_enable && m_wr) begin
      mem[m_addr[15:2]]    <= m_wdata;
      mem_wr[m_addr[15:2]] <= 1'b1;
    end
  end

  // Expected memory image, updated only from the writes the tests intend.
  bit [31:0] ref_mem [16384];
  bit        ref_wr  [16384];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int idx;
    idx = int'(a[15:2]);
    return ref_wr[idx] ? ref_mem[idx] : init_word(idx);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] v);
    ref_mem[int'(a[15:2])] = v;
    ref_wr[int'(a[15:2])]  = 1'b1;
  endtask

  // Per-cycle bus activity, sampled at the edge that closes each cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_enable) en_cnt <= en_cnt + 1;
    if (m_wr) begin
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    if (m_createdump) begin
      dump_cnt <= dump_cnt + 1;
      dump_cyc <= cyc;
    end
    if (i_done) i_done_cnt <= i_done_cnt + 1;
    if (d_done) d_done_cnt <= d_done_cnt + 1;
    if ((m_enable && (m_addr[1:0] != 2'b00 || m_addr[31:16] != 16'h0)) || (m_wr && !m_enable))
      bad_bus_cnt <= bad_bus_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic bit exp_error(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) + 3 >= 65536);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; dump_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Single request from one requester, held until its done pulse.
  task automatic run_access(input bit who_d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int t_req, output int t_done,
                            output logic err, output logic [31:0] rdata, output bit to);
    @(posedge clk); #1;
    if (who_d) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    t_req = cyc; t_done = -1; err = 1'b0; rdata = '0; to = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (who_d ? d_done : i_done) begin
        t_done = cyc;
        err    = who_d ? d_err : i_err;
        rdata  = who_d ? d_rdata : i_rdata;
        to     = 1'b0;
        break;
      end
    end
    if (who_d) d_req = 1'b0; else i_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({i_done, i_err, d_done, d_err, m_enable, m_wr, m_createdump, busy} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000",
                      {i_done, i_err, d_done, d_err, m_enable, m_wr, m_createdump, busy});
    end
    total++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata);
    end
    total++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", m_addr, m_wdata);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] a, v, rd, tmp, prev_rd;
    logic        err;
    int          tr, td, e0, w0;
    bit          to;
    prev_rd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      tmp = $urandom;
      a = (k == 0) ? 32'h10 : {16'h0, tmp[15:2], 2'b00};
      v = (k == 0) ? 32'hDEAD_BEEF : $urandom;
      e0 = en_cnt; w0 = wr_cnt;
      run_access(1'b1, 1'b1, a, v, tr, td, err, rd, to);
      ref_write(a, v);
      total++;
      if (to || td !== tr + LAT + 1) begin
        bad++; $display("FAIL wr_latency: got cycle %0d want %0d (timeout=%0d)", td, tr + LAT + 1, to);
      end
      total++;
      if (err !== 1'b0 || rd !== prev_rd) begin
        bad++; $display("FAIL wr_done: got err=%b rdata=%h want err=0 rdata=%h", err, rd, prev_rd);
      end
      total++;
      if (wr_cnt - w0 !== 1 || wr_cyc !== tr + LAT) begin
        bad++; $display("FAIL wr_strobe: got %0d pulses at %0d want 1 at %0d", wr_cnt - w0, wr_cyc, tr + LAT);
      end
      total++;
      if (en_cnt - e0 !== LAT) begin
        bad++; $display("FAIL wr_enable: got %0d cycles want %0d", en_cnt - e0, LAT);
      end
      w0 = wr_cnt;
      run_access(1'b1, 1'b0, a, 32'h0, tr, td, err, rd, to);
      total++;
      if (to || td !== tr + LAT + 1) begin
        bad++; $display("FAIL rd_latency: got cycle %0d want %0d", td, tr + LAT + 1);
      end
      total++;
      if (err !== 1'b0 || rd !== ref_word(a) || wr_cnt !== w0) begin
        bad++; $display("FAIL rd_data: got err=%b rdata=%h writes=%0d want 0 %h 0", err, rd, wr_cnt - w0, ref_word(a));
      end
      prev_rd = ref_word(a);
    end
    run_access(1'b0, 1'b0, 32'h0000_0100, 32'h0, tr, td, err, rd, to);
    total++;
    if (d_rdata !== prev_rd || rd !== ref_word(32'h100)) begin
      bad++; $display("FAIL rdata_hold: got d=%h i=%h want d=%h i=%h", d_rdata, rd, prev_rd, ref_word(32'h100));
    end
  endtask

  task automatic test_tie();
    int t, ti, td, ov, e0;
    logic [31:0] rdi, rdd;
    do_reset();
    e0 = en_cnt; ti = -1; td = -1; ov = 0; rdi = '0; rdd = '0;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h4;
    t = cyc;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (i_done && d_done) ov++;
      if (d_done && td < 0) begin td = cyc; rdd = d_rdata; d_req = 1'b0; end
      if (i_done && ti < 0) begin ti = cyc; rdi = i_rdata; i_req = 1'b0; end
      if (ti >= 0 && td >= 0) break;
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (td !== t + LAT + 1) begin
      bad++; $display("FAIL tie_d_first: got done %0d want %0d", td, t + LAT + 1);
    end
    total++;
    if (ti !== t + 2 * LAT + 3) begin
      bad++; $display("FAIL tie_i_second: got done %0d want %0d", ti, t + 2 * LAT + 3);
    end
    total++;
    if (rdd !== ref_word(32'h4) || rdi !== ref_word(32'h0)) begin
      bad++; $display("FAIL tie_data: got d=%h i=%h want d=%h i=%h", rdd, rdi, ref_word(32'h4), ref_word(32'h0));
    end
    total++;
    if (en_cnt - e0 !== 2 * LAT || ov !== 0) begin
      bad++; $display("FAIL tie_enable: got %0d enable cycles, %0d overlaps want %0d, 0", en_cnt - e0, ov, 2 * LAT);
    end
  endtask

  task automatic test_alternate();
    int n, who [6], tc [6];
    logic [31:0] tmp, rd [6];
    do_reset();
    n = 0;
    @(posedge clk); #1;
    tmp = $urandom;
    i_req = 1'b1; i_addr = {16'h0, tmp[15:2], 2'b00};
    tmp = $urandom;
    d_req = 1'b1; d_wr = 1'b0; d_addr = {16'h0, tmp[15:2], 2'b00};
    for (int k = 0; k < 200 && n < 6; k++) begin
      @(negedge clk);
      if (d_done) begin who[n] = 1; tc[n] = cyc; rd[n] = d_rdata; n++; end
      else if (i_done) begin who[n] = 0; tc[n] = cyc; rd[n] = i_rdata; n++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (n !== 6) begin
      bad++; $display("FAIL alt_count: got %0d dones want 6", n);
    end
    for (int k = 0; k < n; k++) begin
      total++;
      if (who[k] !== ((k % 2 == 0) ? 1 : 0) || rd[k] !== ref_word((k % 2 == 0) ? d_addr : i_addr)
          || (k > 0 && tc[k] - tc[k-1] !== LAT + 2)) begin
        bad++; $display("FAIL alt_grant%0d: got who=%0d gap=%0d want who=%0d gap=%0d",
                        k, who[k], (k > 0) ? tc[k] - tc[k-1] : 0, (k % 2 == 0) ? 1 : 0, LAT + 2);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [8];
    bit          whos  [8];
    bit          wrs   [8];
    logic [31:0] rd, v;
    logic        err;
    int          tr, td, e0, w0;
    bit          to, xe;
    addrs = '{32'h0000_0002, 32'h0000_FFFE, 32'h0000_FFFC, 32'h0000_FFFD,
              32'h0001_0000, 32'hFFFF_FFFC, 32'h0000_FFFC, 32'h0000_FFF8};
    whos  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    wrs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++) begin
      xe = exp_error(addrs[k]);
      v = $urandom;
      e0 = en_cnt; w0 = wr_cnt;
      run_access(whos[k], wrs[k], addrs[k], v, tr, td, err, rd, to);
      total++;
      if (to || err !== xe || td !== tr + (xe ? 1 : LAT + 1)) begin
        bad++; $display("FAIL err_case%0d: got err=%b done=%0d want err=%b done=%0d",
                        k, err, td, xe, tr + (xe ? 1 : LAT + 1));
      end
      total++;
      if (en_cnt - e0 !== (xe ? 0 : LAT) || wr_cnt - w0 !== ((!xe && wrs[k]) ? 1 : 0)) begin
        bad++; $display("FAIL err_bus%0d: got en=%0d wr=%0d want en=%0d wr=%0d", k, en_cnt - e0,
                        wr_cnt - w0, xe ? 0 : LAT, (!xe && wrs[k]) ? 1 : 0);
      end
      if (!xe && wrs[k]) ref_write(addrs[k], v);
      if (!xe && !wrs[k]) begin
        total++;
        if (rd !== ref_word(addrs[k])) begin
          bad++; $display("FAIL err_rdata%0d: got %h want %h", k, rd, ref_word(addrs[k]));
        end
      end
    end
  endtask

  task automatic test_dump();
    int t, ti, td, d0;
    logic [31:0] tmp, rdi, rdd;
    // Dump requested while idle, together with a fetch.
    d0 = dump_cnt; ti = -1; rdi = '0;
    tmp = $urandom;
    @(posedge clk); #1;
    dump_req = 1'b1; i_req = 1'b1; i_addr = {16'h0, tmp[15:2], 2'b00};
    t = cyc;
    @(posedge clk); #1;
    dump_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_done) begin ti = cyc; rdi = i_rdata; break; end
    end
    i_req = 1'b0;
    total++;
    if (dump_cnt - d0 !== 1 || dump_cyc !== t) begin
      bad++; $display("FAIL dump_idle: got %0d strobes at %0d want 1 at %0d", dump_cnt - d0, dump_cyc, t);
    end
    total++;
    if (ti !== t + LAT + 2 || rdi !== ref_word(i_addr)) begin
      bad++; $display("FAIL dump_idle_grant: got done %0d data %h want %0d %h", ti, rdi, t + LAT + 2, ref_word(i_addr));
    end
    // Dump requested twice during an access, fetch waiting behind it.
    d0 = dump_cnt; ti = -1; td = -1; rdi = '0; rdd = '0;
    @(posedge clk); #1;
    tmp = $urandom;
    d_req = 1'b1; d_wr = 1'b0; d_addr = {16'h0, tmp[15:2], 2'b00};
    t = cyc;
    @(posedge clk); #1;
    dump_req = 1'b1; tmp = $urandom; i_req = 1'b1; i_addr = {16'h0, tmp[15:2], 2'b00};
    @(posedge clk); #1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d_done && td < 0) begin td = cyc; rdd = d_rdata; d_req = 1'b0; end
      if (i_done) begin ti = cyc; rdi = i_rdata; break; end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (td !== t + LAT + 1 || rdd !== ref_word(d_addr)) begin
      bad++; $display("FAIL dump_busy_access: got done %0d data %h want %0d %h", td, rdd, t + LAT + 1, ref_word(d_addr));
    end
    total++;
    if (dump_cnt - d0 !== 1 || dump_cyc !== t + LAT + 2) begin
      bad++; $display("FAIL dump_pending: got %0d strobes at %0d want 1 at %0d", dump_cnt - d0, dump_cyc, t + LAT + 2);
    end
    total++;
    if (ti !== t + 2 * LAT + 4 || rdi !== ref_word(i_addr)) begin
      bad++; $display("FAIL dump_then_grant: got done %0d want %0d", ti, t + 2 * LAT + 4);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, tmp, rd;
    logic        err;
    int          w0, dd0, tr, td;
    bit          to;
    tmp = $urandom;
    a = {16'h0, tmp[15:2], 2'b00};
    w0 = wr_cnt; dd0 = d_done_cnt;
    @(posedge clk); #1;
    d_req = 1'b1; d_wr = 1'b1; d_addr = a; d_wdata = ~ref_word(a);
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({i_done, i_err, d_done, d_err, m_enable, m_wr, m_createdump, busy} !== 8'h00
        || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      bad++; $display("FAIL midrst_outputs: got ctrl=%b addr=%h wdata=%h want 0",
                      {i_done, i_err, d_done, d_err, m_enable, m_wr, m_createdump, busy}, m_addr, m_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (wr_cnt !== w0 || d_done_cnt !== dd0) begin
      bad++; $display("FAIL midrst_abort: got %0d writes %0d dones want 0 0", wr_cnt - w0, d_done_cnt - dd0);
    end
    run_access(1'b1, 1'b0, a, 32'h0, tr, td, err, rd, to);
    total++;
    if (to || td !== tr + LAT + 1 || err !== 1'b0 || rd !== ref_word(a)) begin
      bad++; $display("FAIL midrst_fresh: got done %0d err=%b data %h want %0d 0 %h", td, err, rd, tr + LAT + 1, ref_word(a));
    end
  endtask

  task automatic test_random();
    logic [31:0] a, v, tmp, tmp2, rd;
    logic        err;
    int          tr, td, e0, w0;
    bit          to, who, wr, xe;
    for (int n = 0; n < 24; n++) begin
      tmp = $urandom; tmp2 = $urandom; v = $urandom;
      who = tmp[0]; wr = tmp[0] & tmp[1];
      case (tmp[4:2])
        3'd0:    a = {16'h0, tmp2[15:2], 2'b10};
        3'd1:    a = 32'h0001_0000 + {20'h0, tmp2[11:2], 2'b00};
        default: a = 32'h0000_FF00 + {24'h0, tmp2[7:2], 2'b00};
      endcase
      xe = exp_error(a);
      e0 = en_cnt; w0 = wr_cnt;
      run_access(who, wr, a, v, tr, td, err, rd, to);
      total++;
      if (to || err !== xe || td !== tr + (xe ? 1 : LAT + 1) || en_cnt - e0 !== (xe ? 0 : LAT)
          || wr_cnt - w0 !== ((!xe && wr) ? 1 : 0)) begin
        bad++; $display("FAIL rand%0d: addr=%h got err=%b done=%0d en=%0d want err=%b done=%0d en=%0d",
                        n, a, err, td - tr, en_cnt - e0, xe, xe ? 1 : LAT + 1, xe ? 0 : LAT);
      end
      if (!xe && wr) ref_write(a, v);
      if (!xe && !wr) begin
        total++;
        if (rd !== ref_word(a)) begin
          bad++; $display("FAIL rand_data%0d: addr=%h got %h want %h", n, a, rd, ref_word(a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_alternate();
    test_errors();
    test_dump();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    total++;
    if (bad_bus_cnt !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL bus_sanity: got %0d bad bus cycles busy=%b want 0 0", bad_bus_cnt, busy);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
